bs_alu_seq: RTL and testbench

//  Parametrised bit-serial ALU: add, subtract, unsigned multiply on WIDTH-bit operands.

---
 rtl/bs_alu_pkg.sv | 19 +
 rtl/bs_fa_cell.sv | 13 +
 rtl/bs_alu_seq.sv | 149 ++++++++++++++
 tb/tb_bs_alu_seq.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/bs_alu_pkg.sv
// Shared types for the bit-serial ALU: function codes and FSM states.
package bs_alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_ILL = 2'b11
  } alufun_e;

  typedef enum logic [2:0] {
    IDLE,
    ADDSUB,
    MUL_ADD,
    MUL_SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/bs_fa_cell.sv
// Combinational 1-bit full adder; the only arithmetic cell in the serial ALU.
module bs_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/bs_alu_seq.sv
// Bit-serial add/sub/unsigned-multiply ALU built around a single full-adder cell,
// with a start/busy/done handshake and data-independent latency per function.
module bs_alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [1:0]           i_con_alufun,
  input  logic [WIDTH-1:0]     i_data_a,
  input  logic [WIDTH-1:0]     i_data_b,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_data_result,
  output logic                 o_carry,
  output logic                 o_zero,
  output logic                 o_err
);

  import bs_alu_pkg::*;

  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned IW = BW + 1;

  state_e             state, state_nxt;
  alufun_e            fun, req_fun;
  logic [WIDTH-1:0]   a_sh, b_sh;
  logic [2*WIDTH-1:0] res, res_add, res_shift;
  logic               carry;
  logic [BW-1:0]      bit_cnt;
  logic [IW-1:0]      iter_cnt;
  logic               carry_q, zero_q, err_q;
  logic               fa_a, fa_b, fa_sum, fa_cout;
  logic               last_bit, last_iter;

  bs_fa_cell u_fa (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign req_fun   = alufun_e'(i_con_alufun);
  assign last_bit  = (bit_cnt == BW'(WIDTH - 1));
  assign last_iter = (iter_cnt == IW'(WIDTH - 1));
  assign res_add   = {res[2*WIDTH-1:WIDTH], fa_sum, res[WIDTH-1:1]};
  assign res_shift = {carry, res[2*WIDTH-1:1]};

  // Multiply adds A into the upper half of P by rotating both, so P[0] stays
  // put for the whole iteration and A is restored after WIDTH edges.
  always_comb begin
    fa_a = a_sh[0];
    fa_b = b_sh[0] ^ (fun == ALU_SUB);
    if (state == MUL_ADD) begin
      fa_a = res[WIDTH];
      fa_b = res[0] & a_sh[0];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_start) begin
          case (req_fun)
            ALU_ADD, ALU_SUB: state_nxt = ADDSUB;
            ALU_MUL:          state_nxt = MUL_ADD;
            default:          state_nxt = DONE;
          endcase
        end
      end
      ADDSUB:    if (last_bit) state_nxt = DONE;
      MUL_ADD:   if (last_bit) state_nxt = MUL_SHIFT;
      MUL_SHIFT: state_nxt = last_iter ? DONE : MUL_ADD;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      fun      <= ALU_ADD;
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      carry    <= 1'b0;
      bit_cnt  <= '0;
      iter_cnt <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (i_start) begin
            fun      <= req_fun;
            a_sh     <= i_data_a;
            b_sh     <= i_data_b;
            bit_cnt  <= '0;
            iter_cnt <= '0;
            carry    <= (req_fun == ALU_SUB);
            carry_q  <= 1'b0;
            zero_q   <= (req_fun == ALU_ILL);
            err_q    <= (req_fun == ALU_ILL);
            res      <= (req_fun == ALU_MUL) ? {{WIDTH{1'b0}}, i_data_b} : '0;
          end
        end
        ADDSUB: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          res     <= res_add;
          carry   <= fa_cout;
          bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
          if (last_bit) begin
            carry_q <= fa_cout;
            zero_q  <= (res_add == '0);
          end
        end
        MUL_ADD: begin
          a_sh                  <= {a_sh[0], a_sh[WIDTH-1:1]};
          res[2*WIDTH-1:WIDTH]  <= {fa_sum, res[2*WIDTH-1:WIDTH+1]};
          carry                 <= fa_cout;
          bit_cnt               <= last_bit ? '0 : bit_cnt + BW'(1);
        end
        MUL_SHIFT: begin
          res      <= res_shift;
          carry    <= 1'b0;
          iter_cnt <= iter_cnt + IW'(1);
          if (last_iter) begin
            carry_q <= 1'b0;
            zero_q  <= (res_shift == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = (state != IDLE);
  assign o_done        = (state == DONE);
  assign o_data_result = res;
  assign o_carry       = carry_q;
  assign o_zero        = zero_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_bs_alu_seq.sv
// Directed self-checking bench for bs_alu_seq at WIDTH=8.
module tb_bs_alu_seq;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [1:0]  i_con_alufun;
  logic [7:0]  i_data_a;
  logic [7:0]  i_data_b;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_data_result;
  logic        o_carry;
  logic        o_zero;
  logic        o_err;

  int n_cmp = 0;
  int n_err = 0;

  bs_alu_seq #(.WIDTH(8)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_con_alufun  (i_con_alufun),
    .i_data_a      (i_data_a),
    .i_data_b      (i_data_b),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_data_result (o_data_result),
    .o_carry       (o_carry),
    .o_zero        (o_zero),
    .o_err         (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accept at the next rising edge, then count edges until o_done (bounded).
  task automatic accept(input logic [1:0] f, input logic [7:0] a, input logic [7:0] b);
    @(negedge i_clk);
    i_start      = 1'b1;
    i_con_alufun = f;
    i_data_a     = a;
    i_data_b     = b;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!o_done && lat < 200) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] f,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_res, input logic exp_c,
                        input logic exp_z, input int exp_lat);
    int lat;
    accept(f, a, b);
    check({name, ".busy_acc"}, 32'(o_busy), 32'(1));
    check({name, ".err_acc"},  32'(o_err),  32'(f == 2'b11));
    wait_done(lat);
    check({name, ".lat"},   32'(lat),           32'(exp_lat));
    check({name, ".res"},   32'(o_data_result), 32'(exp_res));
    check({name, ".carry"}, 32'(o_carry),       32'(exp_c));
    check({name, ".zero"},  32'(o_zero),        32'(exp_z));
    @(posedge i_clk);
    #1;
    check({name, ".done_pulse"}, 32'(o_done), 32'(0));
    check({name, ".busy_end"},   32'(o_busy), 32'(0));
    check({name, ".res_hold"},   32'(o_data_result), 32'(exp_res));
  endtask

  initial begin
    int lat;
    int ndone;
    i_rst        = 1'b1;
    i_start      = 1'b0;
    i_con_alufun = 2'b00;
    i_data_a     = '0;
    i_data_b     = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst.busy",  32'(o_busy), 32'(0));
    check("rst.done",  32'(o_done), 32'(0));
    check("rst.res",   32'(o_data_result), 32'(0));
    check("rst.carry", 32'(o_carry), 32'(0));
    check("rst.zero",  32'(o_zero), 32'(0));
    check("rst.err",   32'(o_err), 32'(0));
    @(negedge i_clk);
    i_rst = 1'b0;

    run_op("add200_100", 2'b00, 8'd200, 8'd100, 16'h002C, 1'b1, 1'b0, 8);
    run_op("sub5_7",     2'b01, 8'd5,   8'd7,   16'h00FE, 1'b0, 1'b0, 8);
    run_op("sub7_7",     2'b01, 8'd7,   8'd7,   16'h0000, 1'b1, 1'b1, 8);
    run_op("mul255_255", 2'b10, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0, 72);
    run_op("mul0_13",    2'b10, 8'd0,   8'd13,  16'h0000, 1'b0, 1'b1, 72);
    run_op("ill",        2'b11, 8'd9,   8'd9,   16'h0000, 1'b0, 1'b1, 0);
    check("ill.err_hold", 32'(o_err), 32'(1));
    run_op("add3_4",     2'b00, 8'd3,   8'd4,   16'h0007, 1'b0, 1'b0, 8);
    check("add3_4.err",  32'(o_err), 32'(0));

    // start pulsed mid-multiply must be ignored
    accept(2'b10, 8'd3, 8'd4);
    repeat (9) @(posedge i_clk);
    @(negedge i_clk);
    i_start      = 1'b1;
    i_con_alufun = 2'b00;
    i_data_a     = 8'd1;
    i_data_b     = 8'd1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    check("ign.busy", 32'(o_busy), 32'(1));
    wait_done(lat);
    check("ign.lat", 32'(lat + 10), 32'(72));
    check("ign.res", 32'(o_data_result), 32'(16'h000C));
    @(posedge i_clk);
    #1;

    // reset at edge k+30 of a multiply
    accept(2'b10, 8'd255, 8'd255);
    repeat (29) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    check("rstmid.busy", 32'(o_busy), 32'(0));
    check("rstmid.done", 32'(o_done), 32'(0));
    check("rstmid.res",  32'(o_data_result), 32'(0));
    @(negedge i_clk);
    i_rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge i_clk);
      #1;
      if (o_done) ndone++;
    end
    check("rstmid.no_done", 32'(ndone), 32'(0));
    run_op("add1_1", 2'b00, 8'd1, 8'd1, 16'h0002, 1'b0, 1'b0, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
